// File: rtl/cohort_serdes_sched.sv
// Round-robin scheduler that shares one cohort serdes channel among NUM_REQ requesters.
// Grants are locked per input transaction; a tag FIFO routes each response back to its owner.
module cohort_serdes_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_W      = 64,
  parameter int unsigned OUT_W     = 64,
  parameter int unsigned IN_BEATS  = 2,
  parameter int unsigned OUT_BEATS = 1,
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*IN_W-1:0]    req_data_i,
  output logic                       ser_valid_o,
  input  logic                       ser_ready_i,
  output logic [IN_W-1:0]            ser_data_o,
  input  logic                       des_valid_i,
  output logic                       des_ready_o,
  input  logic [OUT_W-1:0]           des_data_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [OUT_W-1:0]           rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int unsigned IdW     = $clog2(NUM_REQ);
  localparam int unsigned InCntW  = $clog2((IN_BEATS > 2) ? IN_BEATS : 2);
  localparam int unsigned OutCntW = $clog2((OUT_BEATS > 2) ? OUT_BEATS : 2);
  localparam int unsigned PtrW    = $clog2((TAG_DEPTH > 2) ? TAG_DEPTH : 2);
  localparam int unsigned CntW    = $clog2(TAG_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [InCntW-1:0]  in_cnt_q, in_cnt_d;
  logic [OutCntW-1:0] out_cnt_q, out_cnt_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    tag_cnt_q, tag_cnt_d;
  logic [IdW-1:0]     tag_mem_q [TAG_DEPTH];

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IdW:0]         pick_sum;
  logic [IdW-1:0]       pick_id;
  logic                 pick_found;
  logic                 ser_hs, des_hs;
  logic                 push, pop;
  logic                 fifo_empty, fifo_full;
  logic [IdW-1:0]       head_tag;

  assign fifo_empty = (tag_cnt_q == '0);
  assign fifo_full  = (tag_cnt_q >= CntW'(TAG_DEPTH));
  assign head_tag   = tag_mem_q[rd_ptr_q];

  // Rotate requests so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    req_dbl    = {req_valid_i, req_valid_i} >> rr_ptr_q;
    req_rot    = req_dbl[NUM_REQ-1:0];
    pick_found = 1'b0;
    pick_sum   = '0;
    pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr_q} + (IdW+1)'(i);
      end
    end
    if (pick_sum >= (IdW+1)'(NUM_REQ)) begin
      pick_id = IdW'(pick_sum - (IdW+1)'(NUM_REQ));
    end else begin
      pick_id = pick_sum[IdW-1:0];
    end
  end

  always_comb begin
    ser_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdW'(i)) ser_data_o = req_data_i[i*IN_W +: IN_W];
    end
  end

  // Request FSM
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    in_cnt_d    = in_cnt_q;
    push        = 1'b0;
    ser_hs      = 1'b0;
    ser_valid_o = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found && !fifo_full) begin
          grant_d  = pick_id;
          in_cnt_d = '0;
          state_d  = StXfer;
        end
      end
      StXfer: begin
        ser_valid_o          = req_valid_i[grant_q];
        req_ready_o[grant_q] = ser_ready_i;
        ser_hs               = req_valid_i[grant_q] && ser_ready_i;
        if (ser_hs) begin
          if (in_cnt_q == InCntW'(IN_BEATS - 1)) begin
            push     = 1'b1;
            rr_ptr_d = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            in_cnt_d = '0;
            state_d  = StIdle;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response routing: head tag selects the requester; serdes is held off when no tag is queued.
  always_comb begin
    rsp_valid_o = '0;
    des_ready_o = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_o[head_tag] = des_valid_i;
      des_ready_o           = rsp_ready_i[head_tag];
    end
    des_hs    = des_valid_i && des_ready_o;
    pop       = 1'b0;
    out_cnt_d = out_cnt_q;
    if (des_hs) begin
      if (out_cnt_q == OutCntW'(OUT_BEATS - 1)) begin
        pop       = 1'b1;
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  assign rsp_data_o = des_data_i;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StXfer) || !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Tag storage needs no reset; validity is tracked by tag_cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_cohort_serdes_sched.sv
// Bench for cohort_serdes_sched: table-driven single transaction, directed corner
// sequences, and randomized traffic against a queue-based transaction model.
module tb_cohort_serdes_sched;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_data;
  logic         ser_valid;
  logic         ser_ready;
  logic [63:0]  ser_data;
  logic         des_valid;
  logic         des_ready;
  logic [63:0]  des_data;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [63:0]  rsp_data;
  logic [1:0]   grant_id;
  logic         busy;

  logic [63:0]  lane [4];
  int           n_cmp = 0;
  int           n_mis = 0;

  cohort_serdes_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .ser_valid_o (ser_valid),
    .ser_ready_i (ser_ready),
    .ser_data_o  (ser_data),
    .des_valid_i (des_valid),
    .des_ready_o (des_ready),
    .des_data_i  (des_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [63:0] dat;
    logic        sr;
    logic        dv;
    logic [63:0] dd;
    logic [3:0]  rr;
    logic [1:0]  e_gnt;
    logic        e_sv;
    logic [63:0] e_sd;
    logic [3:0]  e_rdy;
    logic [3:0]  e_rv;
    logic        e_dr;
    logic        e_busy;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pack_lanes();
    req_data = {lane[3], lane[2], lane[1], lane[0]};
  endtask

  task automatic zero_inputs();
    req_valid = '0;
    ser_ready = 1'b0;
    des_valid = 1'b0;
    des_data  = '0;
    rsp_ready = '0;
    for (int i = 0; i < 4; i++) lane[i] = 64'h5A5A_0000_0000_0000 | 64'(i);
    pack_lanes();
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'h0);
    chk({nm, "_ser_valid"}, 64'(ser_valid), 64'h0);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    chk({nm, "_des_ready"}, 64'(des_ready), 64'h0);
    chk({nm, "_busy"}, 64'(busy), 64'h0);
    chk({nm, "_grant_id"}, 64'(grant_id), 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    #1;
    chk_quiet("reset");
    smp();
    rst_n = 1'b1;
    cyc();
  endtask

  // One full transaction from requester r with no competition.
  task automatic xact(input int r);
    req_valid = 4'b0001 << r;
    smp();
    cyc();
    cyc();
    cyc();
    req_valid = '0;
  endtask

  // Transaction-level reference model
  bit         m_xfer;
  logic [1:0] m_owner, m_rr;
  int         m_beats, m_obeats;
  logic [1:0] m_tags [$];

  initial begin
    logic [3:0]  e_rdy, e_rv;
    logic        e_sv, e_dr;
    logic [63:0] e_sd;
    int          sz0;
    bit          found;
    logic [1:0]  cand;

    tbl[0] = '{4'b0100, 64'hA1, 1'b1, 1'b0, 64'h0,  4'b0000, 2'd0, 1'b0, 64'h0,  4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{4'b0100, 64'hA1, 1'b1, 1'b0, 64'h0,  4'b0000, 2'd2, 1'b1, 64'hA1, 4'b0100, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{4'b0100, 64'hA2, 1'b1, 1'b0, 64'h0,  4'b0000, 2'd2, 1'b1, 64'hA2, 4'b0100, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{4'b0000, 64'h0,  1'b1, 1'b1, 64'hB0, 4'b0100, 2'd2, 1'b0, 64'h0,  4'b0000, 4'b0100, 1'b1, 1'b1};
    tbl[4] = '{4'b0000, 64'h0,  1'b1, 1'b0, 64'h0,  4'b0100, 2'd2, 1'b0, 64'h0,  4'b0000, 4'b0000, 1'b0, 1'b0};

    // Single requester, table-driven
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = tbl[i].rv;
      lane[2]   = tbl[i].dat;
      pack_lanes();
      ser_ready = tbl[i].sr;
      des_valid = tbl[i].dv;
      des_data  = tbl[i].dd;
      rsp_ready = tbl[i].rr;
      smp();
      chk("tbl_grant_id", 64'(grant_id), 64'(tbl[i].e_gnt));
      chk("tbl_ser_valid", 64'(ser_valid), 64'(tbl[i].e_sv));
      if (tbl[i].e_sv) chk("tbl_ser_data", ser_data, tbl[i].e_sd);
      chk("tbl_req_ready", 64'(req_ready), 64'(tbl[i].e_rdy));
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(tbl[i].e_rv));
      chk("tbl_des_ready", 64'(des_ready), 64'(tbl[i].e_dr));
      chk("tbl_rsp_data", rsp_data, tbl[i].dd);
      chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
      cyc();
    end

    // Round robin with all requesters active
    do_reset();
    req_valid = 4'b1111;
    ser_ready = 1'b1;
    des_valid = 1'b1;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("rr_idle_ser_valid", 64'(ser_valid), 64'h0);
      chk("rr_idle_req_ready", 64'(req_ready), 64'h0);
      cyc();
      smp();
      chk("rr_grant_id", 64'(grant_id), 64'(k % 4));
      chk("rr_req_ready_b0", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cyc();
      smp();
      chk("rr_req_ready_b1", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cyc();
    end

    // Stall inside a grant
    do_reset();
    req_valid = 4'b0010;
    ser_ready = 1'b1;
    smp();
    cyc();
    smp();
    chk("stall_grant", 64'(grant_id), 64'd1);
    cyc();
    req_valid = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      smp();
      chk("stall_grant_held", 64'(grant_id), 64'd1);
      chk("stall_ser_valid", 64'(ser_valid), 64'h0);
      chk("stall_req_ready", 64'(req_ready), 64'(4'b0010));
      cyc();
    end
    req_valid = 4'b1010;
    smp();
    chk("stall_resume_valid", 64'(ser_valid), 64'h1);
    cyc();
    smp();
    chk("stall_idle_req_ready", 64'(req_ready), 64'h0);
    cyc();
    smp();
    chk("stall_next_grant", 64'(grant_id), 64'd3);
    chk("stall_next_req_ready", 64'(req_ready), 64'(4'b1000));

    // Tag FIFO full, response back-pressure, then release
    do_reset();
    ser_ready = 1'b1;
    xact(0);
    xact(1);
    req_valid = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      smp();
      chk("full_req_ready", 64'(req_ready), 64'h0);
      chk("full_ser_valid", 64'(ser_valid), 64'h0);
      chk("full_busy", 64'(busy), 64'h1);
      cyc();
    end
    des_valid = 1'b1;
    des_data  = 64'hC0;
    for (int j = 0; j < 2; j++) begin
      smp();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
      chk("bp_des_ready", 64'(des_ready), 64'h0);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      cyc();
    end
    rsp_ready = 4'b0001;
    smp();
    chk("bp_release_des_ready", 64'(des_ready), 64'h1);
    cyc();
    rsp_ready = 4'b0000;
    smp();
    chk("bp_next_head", 64'(rsp_valid), 64'(4'b0010));
    chk("bp_still_idle", 64'(req_ready), 64'h0);
    cyc();
    des_valid = 1'b0;
    smp();
    chk("full_then_grant", 64'(grant_id), 64'd2);
    chk("full_then_req_ready", 64'(req_ready), 64'(4'b0100));

    // Async reset in the middle of a transfer
    do_reset();
    ser_ready = 1'b1;
    req_valid = 4'b0100;
    smp();
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk_quiet("midreset");
    smp();
    rst_n = 1'b1;
    cyc();
    smp();
    chk("postreset_grant", 64'(grant_id), 64'd1);
    chk("postreset_req_ready", 64'(req_ready), 64'(4'b0010));

    // Randomized traffic against the model
    do_reset();
    m_xfer = 0; m_owner = '0; m_rr = '0; m_beats = 0; m_obeats = 0;
    m_tags.delete();
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) lane[i] = {$urandom, $urandom};
      pack_lanes();
      ser_ready = ($urandom_range(0, 3) != 0);
      des_valid = 1'($urandom_range(0, 1));
      des_data  = {$urandom, $urandom};
      rsp_ready = 4'($urandom_range(0, 15));

      e_rdy = '0; e_sv = 1'b0; e_sd = '0; e_rv = '0; e_dr = 1'b0;
      if (m_xfer) begin
        e_sv           = req_valid[m_owner];
        e_rdy[m_owner] = ser_ready;
        e_sd           = lane[m_owner];
      end
      if (m_tags.size() > 0) begin
        e_rv[m_tags[0]] = des_valid;
        e_dr            = rsp_ready[m_tags[0]];
      end

      smp();
      chk("rnd_req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rnd_ser_valid", 64'(ser_valid), 64'(e_sv));
      if (e_sv) chk("rnd_ser_data", ser_data, e_sd);
      chk("rnd_rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rnd_des_ready", 64'(des_ready), 64'(e_dr));
      chk("rnd_rsp_data", rsp_data, des_data);
      chk("rnd_grant_id", 64'(grant_id), 64'(m_owner));
      chk("rnd_busy", 64'(busy), 64'(m_xfer || (m_tags.size() > 0)));

      sz0 = m_tags.size();
      if (sz0 > 0 && des_valid && rsp_ready[m_tags[0]]) begin
        m_obeats++;
        if (m_obeats == 1) begin
          void'(m_tags.pop_front());
          m_obeats = 0;
        end
      end
      if (m_xfer) begin
        if (req_valid[m_owner] && ser_ready) begin
          m_beats++;
          if (m_beats == 2) begin
            m_tags.push_back(m_owner);
            m_rr    = m_owner + 2'd1;
            m_beats = 0;
            m_xfer  = 0;
          end
        end
      end else if (req_valid != '0 && sz0 < 2) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          cand = m_rr + 2'(k);
          if (!found && req_valid[cand]) begin
            found   = 1;
            m_owner = cand;
          end
        end
        m_xfer  = 1;
        m_beats = 0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
